// File: rtl/dmem_disp_arb_if.sv
// Data-memory port bundle: the master drives the request, the slave returns read data.
interface dmem_disp_arb_if;
    logic        rden;
    logic        wren;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output rden, output wren, output addr, output wdata, input rdata);
    modport slave  (input rden, input wren, input addr, input wdata, output rdata);
endinterface

// File: rtl/dmem_disp_arb.sv
// Core/RAM data port arbiter with a background fetch of the display word in bus-idle cycles.
// Optional DISP_SNOOP_EN: core writes to DISP_ADDR update disp_data directly.
module dmem_disp_arb #(
    parameter logic [31:0] DISP_ADDR   = 32'h0000_0200,
    parameter int unsigned REFRESH_CYC = 50000
) (
    input  logic            m_clock,
    input  logic            p_reset,
    dmem_disp_arb_if.slave  c_bus,
    dmem_disp_arb_if.master m_bus,
    output logic [31:0]     disp_data,
    output logic            disp_valid
);
    typedef enum logic [1:0] {IDLE, ISSUE, CAPT} state_t;

    localparam logic [23:0] RCNT_LAST = 24'(REFRESH_CYC - 1);

    state_t      state;
    state_t      state_nxt;
    logic [23:0] rcnt;
    logic        pend;
    logic        core_busy;
    logic        rcnt_wrap;
    logic        fetch_fire;
    logic        capt_en;
    logic        snoop_hit;

    assign core_busy   = c_bus.rden | c_bus.wren;
    assign rcnt_wrap   = (rcnt == RCNT_LAST);
    assign c_bus.rdata = m_bus.rdata;

`ifdef DISP_SNOOP_EN
    assign snoop_hit = c_bus.wren && (c_bus.addr == DISP_ADDR);
`else
    assign snoop_hit = 1'b0;
`endif

    // The core always owns the port when it asks; the fetch only fills idle cycles.
    always_comb begin
        state_nxt   = state;
        fetch_fire  = 1'b0;
        capt_en     = 1'b0;
        m_bus.rden  = 1'b0;
        m_bus.wren  = 1'b0;
        m_bus.addr  = 32'h0;
        m_bus.wdata = 32'h0;

        if (core_busy) begin
            m_bus.rden  = c_bus.rden;
            m_bus.wren  = c_bus.wren;
            m_bus.addr  = c_bus.addr;
            m_bus.wdata = c_bus.wdata;
        end

        case (state)
            IDLE: begin
                if (pend) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (!core_busy) begin
                    fetch_fire = 1'b1;
                    m_bus.rden = 1'b1;
                    m_bus.addr = DISP_ADDR;
                    state_nxt  = CAPT;
                end
            end
            CAPT: begin
                capt_en   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A wrap while a request is already pending is simply dropped.
    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            state <= IDLE;
            rcnt  <= 24'd0;
            pend  <= 1'b1;
        end else begin
            state <= state_nxt;
            rcnt  <= rcnt_wrap ? 24'd0 : rcnt + 24'd1;
            if (fetch_fire) begin
                pend <= 1'b0;
            end else if (rcnt_wrap) begin
                pend <= 1'b1;
            end
        end
    end

    // A snooped write is newer than the RAM data being captured, so it wins.
    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            disp_data  <= 32'h0;
            disp_valid <= 1'b0;
        end else if (snoop_hit) begin
            disp_data  <= c_bus.wdata;
            disp_valid <= 1'b1;
        end else if (capt_en) begin
            disp_data  <= m_bus.rdata;
            disp_valid <= 1'b1;
        end
    end
endmodule

// File: tb/tb_dmem_disp_arb.sv
// Bench for dmem_disp_arb: RAM model, refresh/fetch reference model, scenario tasks.
`timescale 1ns/1ps
module tb_dmem_disp_arb;
    localparam logic [31:0] DISP_ADDR = 32'h0000_0200;
    localparam int          RC        = 8;
    localparam int          DISP_IDX  = 128;

    logic        m_clock = 1'b0;
    logic        p_reset = 1'b1;
    logic [31:0] disp_data;
    logic        disp_valid;
    int          n_cmp = 0;
    int          n_bad = 0;

    dmem_disp_arb_if c_bus();
    dmem_disp_arb_if m_bus();

    dmem_disp_arb #(.DISP_ADDR(DISP_ADDR), .REFRESH_CYC(RC)) dut (
        .m_clock   (m_clock),
        .p_reset   (p_reset),
        .c_bus     (c_bus),
        .m_bus     (m_bus),
        .disp_data (disp_data),
        .disp_valid(disp_valid)
    );

    always #5 m_clock = ~m_clock;

    // Synchronous RAM with one-cycle read latency and a backdoor write port.
    logic [31:0] mem [0:1023];
    logic [31:0] ram_q;
    logic        bd_en  = 1'b0;
    logic [9:0]  bd_idx = 10'd0;
    logic [31:0] bd_val = 32'h0;

    always @(posedge m_clock) begin
        if (bd_en) mem[bd_idx] <= bd_val;
        else if (m_bus.wren) mem[m_bus.addr[11:2]] <= m_bus.wdata;
        if (m_bus.rden) ram_q <= mem[m_bus.addr[11:2]];
    end
    assign m_bus.rdata = ram_q;

    // Reference: refresh requests every RC edges, one pending at most, fetch waits for an idle bus.
    int unsigned mdl_edges;
    bit          mdl_pend;
    int          mdl_phase;
    bit          mdl_busy;
    bit          mdl_issued;
    logic [31:0] mdl_fetched;
    logic [31:0] exp_disp;
    logic        exp_valid;

    always @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            mdl_edges = 0;
            mdl_pend  = 1'b1;
            mdl_phase = 0;
            exp_disp  = 32'h0;
            exp_valid = 1'b0;
        end else begin
            mdl_busy   = c_bus.rden | c_bus.wren;
            mdl_issued = 1'b0;
            mdl_edges++;
            if (mdl_phase == 2) begin
                exp_disp  = mdl_fetched;
                exp_valid = 1'b1;
                mdl_phase = 0;
            end else if (mdl_phase == 1) begin
                if (!mdl_busy) begin
                    mdl_fetched = mem[DISP_IDX];
                    mdl_phase   = 2;
                    mdl_pend    = 1'b0;
                    mdl_issued  = 1'b1;
                end
            end else if (mdl_pend) begin
                mdl_phase = 1;
            end
            if ((mdl_edges % RC) == 0 && !mdl_issued) mdl_pend = 1'b1;
`ifdef DISP_SNOOP_EN
            if (c_bus.wren && c_bus.addr == DISP_ADDR) begin
                exp_disp  = c_bus.wdata;
                exp_valid = 1'b1;
            end
`endif
        end
    end

    logic        exp_busy;
    logic        exp_rden;
    logic        exp_wren;
    logic [31:0] exp_addr;
    assign exp_busy = c_bus.rden | c_bus.wren;
    assign exp_rden = exp_busy ? c_bus.rden : (mdl_phase == 1);
    assign exp_wren = exp_busy ? c_bus.wren : 1'b0;
    assign exp_addr = exp_busy ? c_bus.addr : ((mdl_phase == 1) ? DISP_ADDR : 32'h0);

    task automatic drive(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wd);
        @(negedge m_clock);
        c_bus.rden  = rd;
        c_bus.wren  = wr;
        c_bus.addr  = addr;
        c_bus.wdata = wd;
        bd_en       = 1'b0;
        #1;
    endtask

    // Holds reset low and preloads RAM words 0..15 and the display word; caller releases.
    task automatic apply_reset();
        c_bus.rden  = 1'b0;
        c_bus.wren  = 1'b0;
        c_bus.addr  = 32'h0;
        c_bus.wdata = 32'h0;
        p_reset     = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge m_clock);
            bd_en  = 1'b1;
            bd_idx = 10'(i);
            bd_val = 32'h1000_0000 | 32'(i << 2);
        end
        @(negedge m_clock);
        bd_idx = 10'(DISP_IDX);
        bd_val = 32'h0012_3456;
        @(negedge m_clock);
        bd_en = 1'b0;
    endtask

    task automatic backdoor_disp(input logic [31:0] val);
        @(negedge m_clock);
        c_bus.rden = 1'b0;
        c_bus.wren = 1'b0;
        bd_en      = 1'b1;
        bd_idx     = 10'(DISP_IDX);
        bd_val     = val;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        n_cmp++;
        if (disp_data !== 32'h0 || disp_valid !== 1'b0 || m_bus.rden !== 1'b0 || m_bus.addr !== 32'h0) begin
            n_bad++;
            $display("[TB] FAIL reset_state: got disp=%h v=%b rd=%b addr=%h want 0/0/0/0", disp_data, disp_valid, m_bus.rden, m_bus.addr);
        end
        p_reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        n_cmp++;
        if (m_bus.rden !== 1'b1 || m_bus.addr !== DISP_ADDR || m_bus.wren !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL reset_first_fetch: got rd=%b wr=%b addr=%h want 1/0/%h", m_bus.rden, m_bus.wren, m_bus.addr, DISP_ADDR);
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        n_cmp++;
        if (disp_valid !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL reset_valid_early: got %b want 0", disp_valid);
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        n_cmp++;
        if (disp_data !== 32'h0012_3456 || disp_valid !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL reset_capture: got %h/%b want 00123456/1", disp_data, disp_valid);
        end
    endtask

    task automatic test_core_defer();
        apply_reset();
        p_reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b0, 32'h10, 32'h0);
            n_cmp++;
            if (m_bus.rden !== 1'b1 || m_bus.wren !== 1'b0 || m_bus.addr !== 32'h10) begin
                n_bad++;
                $display("[TB] FAIL defer_bus cyc %0d: got rd=%b wr=%b addr=%h want 1/0/00000010", i, m_bus.rden, m_bus.wren, m_bus.addr);
            end
            if (i > 0) begin
                n_cmp++;
                if (c_bus.rdata !== 32'h1000_0010) begin
                    n_bad++;
                    $display("[TB] FAIL defer_rdata cyc %0d: got %h want 10000010", i, c_bus.rdata);
                end
            end
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        n_cmp++;
        if (m_bus.rden !== 1'b1 || m_bus.addr !== DISP_ADDR || c_bus.rdata !== 32'h1000_0010) begin
            n_bad++;
            $display("[TB] FAIL defer_issue: got rd=%b addr=%h rdata=%h want 1/%h/10000010", m_bus.rden, m_bus.addr, c_bus.rdata, DISP_ADDR);
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        n_cmp++;
        if (disp_data !== 32'h0012_3456 || disp_valid !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL defer_capture: got %h/%b want 00123456/1", disp_data, disp_valid);
        end
    endtask

    task automatic test_refresh();
        int issues[$];
        bit seen;
        backdoor_disp(32'hA5A5_0001);
        seen = 1'b0;
        for (int i = 1; i <= RC + 3 && !seen; i++) begin
            drive(1'b0, 1'b0, 32'h0, 32'h0);
            if (disp_data === 32'hA5A5_0001) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("[TB] FAIL refresh_update: got %h want a5a50001 within %0d clocks", disp_data, RC + 3);
        end
        for (int i = 0; i < 5 * RC; i++) begin
            drive(1'b0, 1'b0, 32'h0, 32'h0);
            if (m_bus.rden === 1'b1 && m_bus.addr === DISP_ADDR) issues.push_back(i);
        end
        n_cmp++;
        if (issues.size() < 4) begin
            n_bad++;
            $display("[TB] FAIL refresh_count: got %0d fetches want >= 4", issues.size());
        end
        for (int k = 1; k < issues.size(); k++) begin
            n_cmp++;
            if (issues[k] - issues[k-1] != RC) begin
                n_bad++;
                $display("[TB] FAIL refresh_interval %0d: got %0d want %0d", k, issues[k] - issues[k-1], RC);
            end
        end
    endtask

    task automatic test_snoop();
        bit seen;
        backdoor_disp(32'h0000_0001);
        seen = 1'b0;
        for (int i = 0; i < RC + 2 && !seen; i++) begin
            drive(1'b0, 1'b0, 32'h0, 32'h0);
            if (m_bus.rden === 1'b1 && m_bus.addr === DISP_ADDR) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("[TB] FAIL snoop_find_issue: got no fetch want one within %0d clocks", RC + 2);
        end
        drive(1'b0, 1'b1, DISP_ADDR, 32'hCAFE_0042);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
`ifdef DISP_SNOOP_EN
        n_cmp++;
        if (disp_data !== 32'hCAFE_0042) begin
            n_bad++;
            $display("[TB] FAIL snoop_wins: got %h want cafe0042", disp_data);
        end
`else
        n_cmp++;
        if (disp_data !== 32'h0000_0001) begin
            n_bad++;
            $display("[TB] FAIL snoop_stale: got %h want 00000001", disp_data);
        end
        seen = 1'b0;
        for (int i = 0; i < RC + 3 && !seen; i++) begin
            drive(1'b0, 1'b0, 32'h0, 32'h0);
            if (disp_data === 32'hCAFE_0042) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("[TB] FAIL snoop_refresh: got %h want cafe0042", disp_data);
        end
`endif
    endtask

    task automatic test_reset_capt();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < RC + 2 && !seen; i++) begin
            drive(1'b0, 1'b0, 32'h0, 32'h0);
            if (m_bus.rden === 1'b1 && m_bus.addr === DISP_ADDR) seen = 1'b1;
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        n_cmp++;
        if (!seen || disp_valid !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL rcapt_setup: got seen=%b valid=%b want 1/1", seen, disp_valid);
        end
        p_reset = 1'b0;
        #1;
        n_cmp++;
        if (disp_data !== 32'h0 || disp_valid !== 1'b0 || m_bus.rden !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL rcapt_async: got %h/%b rd=%b want 0/0/0", disp_data, disp_valid, m_bus.rden);
        end
        @(negedge m_clock);
        p_reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        n_cmp++;
        if (m_bus.rden !== 1'b1 || m_bus.addr !== DISP_ADDR) begin
            n_bad++;
            $display("[TB] FAIL rcapt_restart: got rd=%b addr=%h want 1/%h", m_bus.rden, m_bus.addr, DISP_ADDR);
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        n_cmp++;
        if (disp_data !== 32'hCAFE_0042 || disp_valid !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL rcapt_refetch: got %h/%b want cafe0042/1", disp_data, disp_valid);
        end
    endtask

    task automatic test_random();
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 2))
                0: begin rd = 1'b1; wr = 1'b0; end
                1: begin rd = 1'b0; wr = 1'b1; end
                default: begin rd = 1'b0; wr = 1'b0; end
            endcase
            if ($urandom_range(0, 2) == 0) rd = 1'b0;
            if ($urandom_range(0, 2) == 0) wr = 1'b0;
            addr = ($urandom_range(0, 3) == 0) ? DISP_ADDR : 32'($urandom_range(0, 15) << 2);
            drive(rd, wr, addr, $urandom);
            n_cmp++;
            if (m_bus.rden !== exp_rden || m_bus.wren !== exp_wren || m_bus.addr !== exp_addr ||
                (exp_busy && m_bus.wdata !== c_bus.wdata)) begin
                n_bad++;
                $display("[TB] FAIL rand_mux cyc %0d: got rd=%b wr=%b addr=%h wd=%h want rd=%b wr=%b addr=%h wd=%h",
                         i, m_bus.rden, m_bus.wren, m_bus.addr, m_bus.wdata, exp_rden, exp_wren, exp_addr, c_bus.wdata);
            end
            n_cmp++;
            if (c_bus.rdata !== ram_q) begin
                n_bad++;
                $display("[TB] FAIL rand_rdata cyc %0d: got %h want %h", i, c_bus.rdata, ram_q);
            end
            n_cmp++;
            if (disp_data !== exp_disp || disp_valid !== exp_valid) begin
                n_bad++;
                $display("[TB] FAIL rand_disp cyc %0d: got %h/%b want %h/%b", i, disp_data, disp_valid, exp_disp, exp_valid);
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_core_defer();
        test_refresh();
        test_snoop();
        test_reset_capt();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] simulation time limit reached");
    end
endmodule

// File: doc/dmem_disp_arb.md
# dmem_disp_arb

Data-memory arbiter between `rv32i_core`'s data port and `ram_wrap`, with a background fetcher that keeps the display word current for `seg7_ctrl`. The core always has priority on the RAM port. In bus-idle cycles the block periodically issues its own read of the display word at `DISP_ADDR` and latches the result on a stable `disp_data` output. This replaces the static mode-driven address mux at top level: the display updates while the core runs, with no mode switch.

## Interface
- `DISP_ADDR`, default 32'h0000_0200: RAM byte address of the display word.
- `REFRESH_CYC`, default 50000: refresh period in clocks; legal range 2..2^24-1.
- `m_clock` in 1: the only clock; all state updates on its rising edge.
- `p_reset` in 1: reset, asynchronous and active-low; assertion clears all state immediately.
- `c_rden` in 1: core data read request, single-cycle.
- `c_wren` in 1: core data write request, single-cycle; mutually exclusive with `c_rden`.
- `c_addr` in 32: core data address.
- `c_wdata` in 32: core write data.
- `c_rdata` out 32: read data to core; equals `m_rdata`, combinational.
- `m_addr` out 32: RAM address.
- `m_wdata` out 32: RAM write data.
- `m_rden` out 1: RAM read enable.
- `m_wren` out 1: RAM write enable.
- `m_rdata` in 32: RAM read data, valid one clock after `m_rden`.
- `disp_data` out 32: latched display word for `seg7_ctrl`.
- `disp_valid` out 1: high once `disp_data` has been loaded at least once since reset.

## Operation
- Port mux, combinational:
  - If `c_rden` or `c_wren` is high, `m_*` carry the core request unchanged and `m_rden`/`m_wren` mirror the core enables.
  - Otherwise, in state ISSUE, `m_addr`=`DISP_ADDR`, `m_rden`=1, `m_wren`=0.
  - Otherwise, `m_addr`=0, `m_wdata`=0, and both enables are 0.
- Refresh counter `rcnt`, 24-bit: counts 0..`REFRESH_CYC`-1 and wraps. On wrap it sets `pend`. Wraps that occur while `pend` is already set are dropped; there is no queue.
- FSM:
  - IDLE: go to ISSUE if `pend`.
  - ISSUE: if the core holds the bus this cycle, stay in ISSUE (deferred; nothing is issued). If not, the display read is issued, `pend` clears, and the FSM goes to CAPT.
  - CAPT: `disp_data` <= `m_rdata`, `disp_valid` <= 1, FSM goes to IDLE.
- Core priority is absolute. If the core accesses the bus every cycle, the fetch is deferred indefinitely; this is allowed, and no core stall exists.
- A core read issued in a CAPT cycle gets its data one cycle later. There is no collision on `m_rdata`.
- Reset mid-fetch: the FSM returns to IDLE and any capture in flight is discarded.

## Timing
- Reset values:
  - `disp_data`=0, `disp_valid`=0, FSM=IDLE, `rcnt`=0.
  - `pend`=1, so the first fetch starts on the first clock after release.
  - Mux outputs follow their combinational rule; with no core request and the FSM in IDLE, all `m_*` outputs are 0.
- Fetch latency with an idle bus: `pend` high at edge N → ISSUE during cycle N+1 → CAPT during N+2 → `disp_data` updated at edge N+3.
- Each clock of core bus activity while in ISSUE adds one cycle of latency.
- Steady-state refresh interval is `REFRESH_CYC` clocks when the bus is idle.
- `c_rdata` adds zero latency to the RAM path.

## Configuration
- `DISP_SNOOP_EN` defined:
  - A core write with `c_addr`==`DISP_ADDR` loads `disp_data` <= `c_wdata` and sets `disp_valid` at that edge.
  - If the snoop and a CAPT land in the same cycle, the snoop wins, because the RAM data is older.
  - Writes to other addresses have no effect on `disp_data`.
- `DISP_SNOOP_EN` undefined:
  - `disp_data` changes only in CAPT.
  - Staleness is bounded by `REFRESH_CYC` plus the deferral cycles.

## Test plan
- Reset release, idle bus, RAM[0x200]=32'h0012_3456 → `m_rden`=1 with `m_addr`=0x200 in the first cycle after release; `disp_data`=32'h0012_3456 and `disp_valid`=1 three edges after release.
- Core reads 0x10 every cycle for 20 cycles while `pend` is set → `m_addr`=0x10 throughout and no display read; the display read is issued in the first idle cycle, and `c_rdata` returns the RAM data at 0x10 each cycle.
- `REFRESH_CYC`=8, idle bus, RAM[0x200] changed to 32'hA5A5_0001 by a testbench backdoor → `disp_data` shows the new value within 8+3 clocks; fetch reads occur every 8 clocks.
- Core write 32'hCAFE_0042 to 0x200 with `DISP_SNOOP_EN` defined, in a CAPT cycle that captures the old 32'h1 → `disp_data`=32'hCAFE_0042 next cycle; without the macro, the old value stays until the next refresh, which then shows 32'hCAFE_0042.
- `p_reset` asserted low during CAPT → `disp_data`=0 and `disp_valid`=0 immediately, without a clock edge; after release, the fetch restarts per the first scenario.
